// File: rtl/blvds_link_ctrl_if.sv
// Fabric word interface plus the BLVDS pad-buffer pins of blvds_link_ctrl.
// The master side is the environment: the fabric and the din leg of the pad buffer.
interface blvds_link_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              busy;
    logic              oe;
    logic              doutp;
    logic              din;

    modport master (
        output tx_data, tx_valid, din,
        input  tx_ready, rx_data, rx_valid, rx_err, busy, oe, doutp
    );

    modport slave (
        input  tx_data, tx_valid, din,
        output tx_ready, rx_data, rx_valid, rx_err, busy, oe, doutp
    );
endinterface

// File: rtl/blvds_link_ctrl.sv
// Half-duplex BLVDS link controller: frames words onto the pair (start 1, data MSB first,
// stop 0), releases the bus for a turnaround gap, and deserialises frames seen on din.
module blvds_link_ctrl #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int TURN_CLKS    = 3
) (
    input  logic              clk,
    input  logic              rst,
    blvds_link_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (CLKS_PER_BIT > TURN_CLKS) ? CLKS_PER_BIT : TURN_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CLKS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TURN,
        RX_START,
        RX_DATA,
        RX_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_err_q, rx_err_d;
    logic              ready_en_q, ready_en_d;
    logic              din_meta_q, din_meta_d;
    logic              din_s_q, din_s_d;

    logic tx_ready;
    logic cyc_wrap;
    logic tx_active;

    // A pending receive start blocks acceptance in the same cycle, so RX always wins.
    assign tx_ready  = (state_q == IDLE) && ready_en_q && !din_s_q;
    assign cyc_wrap  = (cyc_q == BIT_LAST);
    assign tx_active = (state_q == TX_START) || (state_q == TX_DATA) || (state_q == TX_STOP);

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q + 1'b1;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        ready_en_d = 1'b1;
        din_meta_d = bus.din;
        din_s_d    = din_meta_q;

        case (state_q)
            IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (din_s_q) begin
                    state_d = RX_START;
                end else if (bus.tx_valid && tx_ready) begin
                    sh_d    = bus.tx_data;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cyc_wrap) begin
                    cyc_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (cyc_wrap) begin
                    cyc_d = '0;
                    sh_d  = sh_q << 1;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == DATA_LAST) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (cyc_wrap) begin
                    cyc_d   = '0;
                    state_d = TURN;
                end
            end
            TURN: begin
                if (cyc_q == TURN_LAST) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                end
            end
            RX_START: begin
                // Re-check at mid start bit; a low line here was only a glitch.
                if (cyc_q == HALF_LAST) begin
                    cyc_d   = '0;
                    state_d = din_s_q ? RX_DATA : IDLE;
                end
            end
            RX_DATA: begin
                if (cyc_wrap) begin
                    cyc_d = '0;
                    sh_d  = (sh_q << 1) | DATA_W'(din_s_q);
                    bit_d = bit_q + 1'b1;
                    if (bit_q == DATA_LAST) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cyc_wrap) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                    if (!din_s_q) begin
                        rx_data_d  = sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            ready_en_q <= 1'b0;
            din_meta_q <= 1'b0;
            din_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            ready_en_q <= ready_en_d;
            din_meta_q <= din_meta_d;
            din_s_q    <= din_s_d;
        end
    end

    // Pad controls decode straight from state so reset releases the pair without a clock.
    assign bus.oe       = tx_active;
    assign bus.doutp    = (state_q == TX_START) ? 1'b1 :
                          (state_q == TX_DATA)  ? sh_q[DATA_W-1] : 1'b0;
    assign bus.busy     = (state_q != IDLE);
    assign bus.tx_ready = tx_ready;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;

endmodule

// File: doc/blvds_link_ctrl.md
Name: blvds_link_ctrl

Overview:
Half-duplex serial link controller that sequences one bidirectional BLVDS pad buffer (oe/doutp/din) between transmit and receive. It serialises parallel words into framed bit streams with output enable asserted. It then inserts a bus-turnaround gap and returns to listening, deserialising incoming frames. It sits between the fabric-side word interface and the CycloneIII_blvds buffer instance.

Parameters:
DATA_W, 8, payload bits per frame (>=1).
CLKS_PER_BIT, 4, clk cycles per line bit (even, >=4).
TURN_CLKS, 3, cycles of released bus (oe=0) after each transmitted frame (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
tx_data  input  DATA_W  word to transmit; sampled on the accept cycle.
tx_valid  input  1  transmit request.
tx_ready  output  1  high only in IDLE with no receive start pending; the word is accepted when tx_valid & tx_ready.
rx_data  output  DATA_W  last correctly received word; holds its value until the next good frame.
rx_valid  output  1  one-cycle pulse when rx_data updates.
rx_err  output  1  one-cycle pulse on a bad stop bit.
busy  output  1  high in any state other than IDLE.
oe  output  1  to the buffer; 1 = drive the pair, 0 = release it.
doutp  output  1  to the buffer; line data while oe=1.
din  input  1  from the buffer; asynchronous, passes through a 2-flop synchroniser (din_s).

Behaviour:
- Reset (asynchronous, immediate): oe=0, doutp=0, tx_ready=0, rx_valid=0, rx_err=0, busy=0, rx_data=0, state IDLE, synchroniser flops=0. tx_ready rises on the first clk after rst deasserts.
- Line format: idle-low with external bias. Frame = start bit (1), DATA_W data bits MSB first, stop bit (0). Each bit is CLKS_PER_BIT cycles.
- States: IDLE, TX_START, TX_DATA, TX_STOP, TURN, RX_START, RX_DATA, RX_STOP.
- IDLE: oe=0, doutp=0.
  - din_s=1 -> RX_START. This takes priority over a same-cycle tx_valid; tx_ready is already 0 in that cycle.
  - Otherwise tx_valid & tx_ready -> latch tx_data into the shift register, go to TX_START.
- TX_START / TX_DATA / TX_STOP:
  - oe=1 from the first cycle after accept.
  - doutp = start, data bits, then stop; each held CLKS_PER_BIT cycles.
  - A bit counter counts DATA_W bits and a cycle counter wraps at CLKS_PER_BIT-1.
  - Total oe=1 time = (DATA_W+2)*CLKS_PER_BIT cycles.
  - din is ignored (self-echo).
- TURN: oe=0, doutp=0 for TURN_CLKS cycles, then IDLE. din is ignored.
- RX_START:
  - Wait CLKS_PER_BIT/2 cycles, then re-check din_s.
  - If 0 -> false start, return to IDLE with no pulses.
  - If 1 -> RX_DATA.
- RX_DATA: sample din_s every CLKS_PER_BIT cycles (mid-bit), shifting in MSB first, for DATA_W samples; then go to RX_STOP.
- RX_STOP: one CLKS_PER_BIT later, sample the stop bit.
  - 0 -> rx_data <= shift register, rx_valid pulse.
  - 1 -> rx_err pulse, rx_data unchanged.
  - Either way, IDLE on the next cycle.
- oe is 0 in every RX state; the controller never drives during reception.
- rx_valid and rx_err are never high together, and neither is ever high while oe=1.
- Reset mid-frame: oe falls immediately (asynchronous); no partial rx_valid; the current tx word is dropped.

Test Plan:
- Reset then TX 0xA5 (DATA_W=8, CLKS_PER_BIT=4, TURN_CLKS=3), tx_valid accepted at cycle 0:
  - oe=1 during cycles 1..40; doutp pattern 1,1,0,1,0,0,1,0,1,0 per 4-cycle bit.
  - oe=0 during cycles 41..43; tx_ready=1 at cycle 44.
- RX 0x3C: bench drives din idle 0, then start 1, bits 0,0,1,1,1,1,0,0, stop 0, each 4 cycles -> exactly one rx_valid pulse with rx_data=0x3C; oe stays 0 throughout.
- Glitch: din=1 for 1 cycle in IDLE -> return to IDLE, no rx_valid/rx_err, tx_ready back to 1.
- Bad stop: frame 0x81 with stop bit=1 -> rx_err pulse, rx_data keeps its previous value (0x3C), no rx_valid.
- Collision: tx_valid=1 in the same cycle din_s first reads 1 -> no accept; RX frame 0x55 completes with rx_valid. TX then starts with oe=1 on the cycle after tx_ready&tx_valid, and din is ignored throughout the TX frame.
- Reset asserted mid-TX at cycle 20 -> oe=0, doutp=0, busy=0 asynchronously; after release, tx_ready=1 and a new frame transmits cleanly.
